// File: rtl/dcache_responder.sv
// Direct-mapped write-back data cache (8 sets x 16-byte lines) answering pipeline
// memory requests, with 128-bit line fills and writebacks to physical memory.
module dcache_responder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_req,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    input  logic [1:0]   mem_byte_enable,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t         state_reg, state_next;
    logic [8:0]     miss_tag_reg;
    logic [2:0]     miss_index_reg;

    logic [8:0]     req_tag;
    logic [2:0]     req_index;
    logic [2:0]     req_word;
    logic           addr_lsb_unused;

    logic [7:0]     valid_vec;
    logic [7:0]     dirty_vec;
    logic [8:0]     tag_arr  [8];
    logic [127:0]   line_arr [8];

    logic [127:0]   sel_line;
    logic [127:0]   merged_line;
    logic [15:0]    sel_word;
    logic           hit;
    logic           in_idle;
    logic           write_hit;
    logic           miss;
    logic           fill_done;
    logic           wb_done;

    assign req_tag         = mem_address[15:7];
    assign req_index       = mem_address[6:4];
    assign req_word        = mem_address[3:1];
    assign addr_lsb_unused = mem_address[0];

    assign sel_line  = line_arr[req_index];
    assign sel_word  = sel_line[{req_word, 4'b0000} +: 16];
    assign hit       = mem_req & valid_vec[req_index] & (tag_arr[req_index] == req_tag);
    assign in_idle   = (state_reg == IDLE);
    assign write_hit = in_idle & hit & mem_write;
    assign miss      = in_idle & mem_req & ~hit;
    assign fill_done = (state_reg == FILL) & pmem_resp;
    assign wb_done   = (state_reg == WRITEBACK) & pmem_resp;

    always_comb begin
        merged_line = sel_line;
        if (mem_byte_enable[0])
            merged_line[{req_word, 4'b0000} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1])
            merged_line[{req_word, 4'b1000} +: 8] = mem_wdata[15:8];
    end

    // Per-set storage; the miss index is latched so a withdrawn request still installs its line.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : gen_set
            logic         valid_reg;
            logic         dirty_reg;
            logic [8:0]   tag_reg;
            logic [127:0] line_reg;
            logic         fill_sel;
            logic         wb_sel;
            logic         wr_sel;

            assign fill_sel = fill_done & (miss_index_reg == 3'(gi));
            assign wb_sel   = wb_done & (miss_index_reg == 3'(gi));
            assign wr_sel   = write_hit & (req_index == 3'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    dirty_reg <= 1'b0;
                    tag_reg   <= 9'd0;
                    line_reg  <= 128'd0;
                end else if (fill_sel) begin
                    valid_reg <= 1'b1;
                    dirty_reg <= 1'b0;
                    tag_reg   <= miss_tag_reg;
                    line_reg  <= pmem_rdata;
                end else if (wb_sel) begin
                    dirty_reg <= 1'b0;
                end else if (wr_sel) begin
                    dirty_reg <= 1'b1;
                    line_reg  <= merged_line;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign dirty_vec[gi] = dirty_reg;
            assign tag_arr[gi]   = tag_reg;
            assign line_arr[gi]  = line_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            miss_tag_reg   <= 9'd0;
            miss_index_reg <= 3'd0;
        end else begin
            state_reg <= state_next;
            if (miss) begin
                miss_tag_reg   <= req_tag;
                miss_index_reg <= req_index;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        mem_resp     = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'd0;
        case (state_reg)
            IDLE: begin
                if (hit) begin
                    mem_resp = 1'b1;
                    if (!mem_write)
                        mem_rdata = sel_word;
                end else if (mem_req) begin
                    if (valid_vec[req_index] & dirty_vec[req_index])
                        state_next = WRITEBACK;
                    else
                        state_next = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[miss_index_reg], miss_index_reg, 4'b0000};
                pmem_wdata   = line_arr[miss_index_reg];
                if (pmem_resp)
                    state_next = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag_reg, miss_index_reg, 4'b0000};
                if (pmem_resp)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: fills, hits, byte writes, dirty eviction,
// withdrawn requests and asynchronous reset during a fill.
module tb_dcache_responder;

    logic         clk;
    logic         rst_n;
    logic         mem_req;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int total = 0;
    int bad   = 0;

    dcache_responder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_req         (mem_req),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] LINE_A = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                       16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
    localparam logic [127:0] LINE_A_MOD = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                           16'h3333, 16'hBEAA, 16'h1111, 16'h0000};
    localparam logic [127:0] LINE_B = {16'hB777, 16'hB666, 16'hB555, 16'hB444,
                                       16'hB333, 16'hCAFE, 16'hB111, 16'hB000};
    localparam logic [127:0] LINE_C = {16'hC777, 16'hC666, 16'hC555, 16'hC444,
                                       16'hC333, 16'hC222, 16'hC111, 16'h5A5A};

    initial begin
        rst_n           = 1'b0;
        mem_req         = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 16'h0000;
        mem_wdata       = 16'h0000;
        mem_byte_enable = 2'b11;
        pmem_rdata      = 128'd0;
        pmem_resp       = 1'b0;
        step();
        step();
        chk("rst_resp",   {127'd0, mem_resp},   128'd0);
        chk("rst_rdata",  {112'd0, mem_rdata},  128'd0);
        chk("rst_pread",  {127'd0, pmem_read},  128'd0);
        chk("rst_pwrite", {127'd0, pmem_write}, 128'd0);
        chk("rst_paddr",  {112'd0, pmem_address}, 128'd0);
        chk("rst_pwdata", pmem_wdata, 128'd0);
        rst_n = 1'b1;
        step();

        // Cold read 0x0124 -> fill from 0x0120
        mem_req = 1'b1; mem_write = 1'b0; mem_address = 16'h0124;
        #1;
        chk("cold_resp0", {127'd0, mem_resp}, 128'd0);
        chk("cold_pread0", {127'd0, pmem_read}, 128'd0);
        step();
        chk("cold_pread", {127'd0, pmem_read}, 128'd1);
        chk("cold_pwrite", {127'd0, pmem_write}, 128'd0);
        chk("cold_paddr", {112'd0, pmem_address}, {112'd0, 16'h0120});
        chk("cold_rdata_busy", {112'd0, mem_rdata}, 128'd0);
        pmem_rdata = LINE_A; pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        #1;
        chk("cold_resp", {127'd0, mem_resp}, 128'd1);
        chk("cold_rdata", {112'd0, mem_rdata}, {112'd0, 16'hBEEF});
        chk("cold_pread_done", {127'd0, pmem_read}, 128'd0);
        step();

        // Read hit on word 7
        mem_address = 16'h012E;
        #1;
        chk("hit_resp", {127'd0, mem_resp}, 128'd1);
        chk("hit_rdata", {112'd0, mem_rdata}, {112'd0, 16'h7777});
        chk("hit_pmem", {126'd0, pmem_read, pmem_write}, 128'd0);
        step();

        // Byte write low byte of word 2
        mem_write = 1'b1; mem_address = 16'h0124; mem_wdata = 16'h12AA; mem_byte_enable = 2'b01;
        #1;
        chk("bwr_resp", {127'd0, mem_resp}, 128'd1);
        step();
        mem_write = 1'b0; mem_byte_enable = 2'b11;
        #1;
        chk("bwr_readback", {112'd0, mem_rdata}, {112'd0, 16'hBEAA});
        step();

        // Dirty eviction: 0x0A24 shares index 2
        mem_address = 16'h0A24;
        #1;
        chk("evict_resp0", {127'd0, mem_resp}, 128'd0);
        step();
        chk("wb_pwrite", {127'd0, pmem_write}, 128'd1);
        chk("wb_pread", {127'd0, pmem_read}, 128'd0);
        chk("wb_paddr", {112'd0, pmem_address}, {112'd0, 16'h0120});
        chk("wb_pwdata", pmem_wdata, LINE_A_MOD);
        chk("wb_resp", {127'd0, mem_resp}, 128'd0);
        step();
        chk("wb_hold", {127'd0, pmem_write}, 128'd1);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        #1;
        chk("ev_fill_pread", {127'd0, pmem_read}, 128'd1);
        chk("ev_fill_pwrite", {127'd0, pmem_write}, 128'd0);
        chk("ev_fill_paddr", {112'd0, pmem_address}, {112'd0, 16'h0A20});
        pmem_rdata = LINE_B; pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        #1;
        chk("ev_resp", {127'd0, mem_resp}, 128'd1);
        chk("ev_rdata", {112'd0, mem_rdata}, {112'd0, 16'hCAFE});
        step();

        // Withdrawn request during fill of 0x0350
        mem_address = 16'h0350;
        step();
        mem_req = 1'b0;
        #1;
        chk("wd_pread", {127'd0, pmem_read}, 128'd1);
        chk("wd_paddr", {112'd0, pmem_address}, {112'd0, 16'h0350});
        pmem_rdata = LINE_C; pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        #1;
        chk("wd_idle_pread", {127'd0, pmem_read}, 128'd0);
        chk("wd_no_resp", {127'd0, mem_resp}, 128'd0);
        // Stray pmem_resp in IDLE must be ignored
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        chk("idle_resp_ign", {126'd0, pmem_read, pmem_write}, 128'd0);
        mem_req = 1'b1;
        #1;
        chk("wd_hit_resp", {127'd0, mem_resp}, 128'd1);
        chk("wd_hit_rdata", {112'd0, mem_rdata}, {112'd0, 16'h5A5A});
        step();

        // Reset during a fill of 0x0124 (evicted earlier, clean victim now)
        mem_address = 16'h0124;
        step();
        chk("rf_pread", {127'd0, pmem_read}, 128'd1);
        chk("rf_pwrite", {127'd0, pmem_write}, 128'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rf_async_pread", {127'd0, pmem_read}, 128'd0);
        chk("rf_async_resp", {127'd0, mem_resp}, 128'd0);
        mem_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        mem_req = 1'b1; mem_address = 16'h0350;
        #1;
        chk("rr_miss_resp", {127'd0, mem_resp}, 128'd0);
        step();
        chk("rr_pread", {127'd0, pmem_read}, 128'd1);
        chk("rr_paddr", {112'd0, pmem_address}, {112'd0, 16'h0350});
        pmem_rdata = LINE_C; pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        #1;
        chk("rr_resp", {127'd0, mem_resp}, 128'd1);
        chk("rr_rdata", {112'd0, mem_rdata}, {112'd0, 16'h5A5A});
        mem_req = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (rst_n && pmem_read && pmem_write) begin
            bad++;
            $display("FAIL pmem_exclusive observed=11 expected=not both");
        end
    end

endmodule
